// File: rtl/cordic_seq_pkg.sv
// Shared constants for the CORDIC request sequencer: state encoding,
// default watchdog limit and operation codes.
package cordic_seq_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_ACK    = 3'd3;
  localparam logic [2:0] ST_ABORT  = 3'd4;
  localparam logic [2:0] ST_HOLD   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LAUNCH = ST_LAUNCH,
    WAIT   = ST_WAIT,
    ACK    = ST_ACK,
    ABORT  = ST_ABORT,
    HOLD   = ST_HOLD
  } state_e;

  localparam int MAX_WAIT_DEFAULT = 1024;

  localparam logic OP_COS = 1'b0;
  localparam logic OP_SIN = 1'b1;

endpackage

// File: rtl/cordic_wait_watchdog.sv
// Cycle counter for the WAIT state; flags the last permitted cycle.
module cordic_wait_watchdog #(
  parameter int MAX_WAIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT - 1);

  logic [CW-1:0] count_q, count_d;

  assign expired = (count_q == LIMIT);

  // Holding at the limit keeps the counter from wrapping once it expires.
  always_comb begin
    count_d = count_q;
    if (clear)                   count_d = '0;
    else if (enable && !expired) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/cordic_req_sequencer.sv
// Host-facing front end of the CORDIC core: latches one request, launches
// the core, collects its result (or aborts on watchdog) and hands it back.
module cordic_req_sequencer
  import cordic_seq_pkg::*;
#(
  parameter int W        = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_data,
  input  logic         req_operation,
  input  logic [1:0]   req_region,
  output logic [W-1:0] cordic_data_in,
  output logic         operation,
  output logic [1:0]   shift_region_flag,
  output logic         beg_FSM_CORDIC,
  input  logic         ready_CORDIC,
  input  logic [W-1:0] cordic_data_out,
  output logic         ACK_FSM_CORDIC,
  output logic         cordic_reset,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_timeout
);

  state_e       state_q, state_d;
  logic [W-1:0] opnd_q, opnd_d;
  logic         op_q, op_d;
  logic [1:0]   region_q, region_d;
  logic         beg_q, beg_d;
  logic         ack_q, ack_d;
  logic         crst_q, crst_d;
  logic         rvalid_q, rvalid_d;
  logic [W-1:0] rdata_q, rdata_d;
  logic         rto_q, rto_d;
  logic         wd_expired;

  cordic_wait_watchdog #(.MAX_WAIT(MAX_WAIT)) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == LAUNCH),
    .enable  (state_q == WAIT),
    .expired (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    region_d = region_q;
    beg_d    = 1'b0;
    ack_d    = 1'b0;
    crst_d   = 1'b0;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rto_d    = rto_q;
    case (state_q)
      IDLE: if (req_valid) begin
        opnd_d   = req_data;
        op_d     = req_operation;
        region_d = req_region;
        beg_d    = 1'b1;
        state_d  = LAUNCH;
      end
      LAUNCH: state_d = WAIT;
      // Completion is checked first so a result on the limit cycle is kept.
      WAIT: begin
        if (ready_CORDIC) begin
          rdata_d  = cordic_data_out;
          rto_d    = 1'b0;
          rvalid_d = 1'b1;
          ack_d    = 1'b1;
          state_d  = ACK;
        end else if (wd_expired) begin
          rdata_d  = '0;
          rto_d    = 1'b1;
          rvalid_d = 1'b1;
          crst_d   = 1'b1;
          state_d  = ABORT;
        end
      end
      ACK, ABORT, HOLD: begin
        if (res_ready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d  = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      opnd_q   <= '0;
      op_q     <= 1'b0;
      region_q <= '0;
      beg_q    <= 1'b0;
      ack_q    <= 1'b0;
      crst_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      region_q <= region_d;
      beg_q    <= beg_d;
      ack_q    <= ack_d;
      crst_q   <= crst_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rto_q    <= rto_d;
    end
  end

  assign req_ready         = (state_q == IDLE);
  assign cordic_data_in    = opnd_q;
  assign operation         = op_q;
  assign shift_region_flag = region_q;
  assign beg_FSM_CORDIC    = beg_q;
  assign ACK_FSM_CORDIC    = ack_q;
  assign cordic_reset      = crst_q;
  assign res_valid         = rvalid_q;
  assign res_data          = rdata_q;
  assign res_timeout       = rto_q;

endmodule

// File: tb/tb_cordic_req_sequencer.sv
// Directed bench for cordic_req_sequencer with a short watchdog (MAX_WAIT = 8).
module tb_cordic_req_sequencer;
  import cordic_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_data;
  logic        req_operation;
  logic [1:0]  req_region;
  logic [31:0] cordic_data_in;
  logic        operation;
  logic [1:0]  shift_region_flag;
  logic        beg_FSM_CORDIC, ready_CORDIC, ACK_FSM_CORDIC, cordic_reset;
  logic [31:0] cordic_data_out;
  logic        res_valid, res_ready, res_timeout;
  logic [31:0] res_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic excl_on = 1'b0;

  always #5 clk = ~clk;

  cordic_req_sequencer #(.W(32), .MAX_WAIT(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_data          (req_data),
    .req_operation     (req_operation),
    .req_region        (req_region),
    .cordic_data_in    (cordic_data_in),
    .operation         (operation),
    .shift_region_flag (shift_region_flag),
    .beg_FSM_CORDIC    (beg_FSM_CORDIC),
    .ready_CORDIC      (ready_CORDIC),
    .cordic_data_out   (cordic_data_out),
    .ACK_FSM_CORDIC    (ACK_FSM_CORDIC),
    .cordic_reset      (cordic_reset),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_data          (res_data),
    .res_timeout       (res_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Core-side pulses must never overlap.
  always @(negedge clk)
    if (excl_on)
      chk("excl", 64'($countones({beg_FSM_CORDIC, ACK_FSM_CORDIC, cordic_reset}) <= 1), 64'd1);

  task automatic send(input logic [31:0] d, input logic op, input logic [1:0] rg, input string tag);
    req_valid = 1'b1; req_data = d; req_operation = op; req_region = rg;
    tick();
    req_valid = 1'b0;
    chk({tag, ".beg"},   beg_FSM_CORDIC, 1);
    chk({tag, ".opnd"},  cordic_data_in, d);
    chk({tag, ".op"},    operation, op);
    chk({tag, ".rgn"},   shift_region_flag, rg);
    chk({tag, ".rrdy0"}, req_ready, 0);
  endtask

  // ready_CORDIC is seen at the accept edge + d; leaves ready high after ACK.
  task automatic respond(input int d, input logic [31:0] r, input string tag);
    for (int i = 1; i < d; i++) begin
      tick();
      chk({tag, ".wbeg"}, beg_FSM_CORDIC, 0);
      chk({tag, ".wack"}, ACK_FSM_CORDIC, 0);
    end
    ready_CORDIC = 1'b1; cordic_data_out = r;
    tick();
    chk({tag, ".ack"},  ACK_FSM_CORDIC, 1);
    chk({tag, ".rv"},   res_valid, 1);
    chk({tag, ".rd"},   res_data, r);
    chk({tag, ".rto"},  res_timeout, 0);
    chk({tag, ".crst"}, cordic_reset, 0);
  endtask

  task automatic finish_ok(input string tag);
    tick();
    ready_CORDIC = 1'b0;
    chk({tag, ".ack0"}, ACK_FSM_CORDIC, 0);
    chk({tag, ".rv0"},  res_valid, 0);
    chk({tag, ".rrdy"}, req_ready, 1);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_data = '0; req_operation = 1'b0;
    req_region = '0; ready_CORDIC = 1'b0; cordic_data_out = '0; res_ready = 1'b0;
    repeat (2) tick();
    chk("rst.rrdy", req_ready, 1);
    chk("rst.beg",  beg_FSM_CORDIC, 0);
    chk("rst.ack",  ACK_FSM_CORDIC, 0);
    chk("rst.crst", cordic_reset, 0);
    chk("rst.rv",   res_valid, 0);
    chk("rst.rd",   res_data, 0);
    chk("rst.opnd", cordic_data_in, 0);
    reset = 1'b1;
    tick();
    excl_on = 1'b1;

    // basic: beg at N+1, ACK/res_valid at N+7, req_ready at N+8
    res_ready = 1'b1;
    send(32'h3F490FDB, OP_SIN, 2'b01, "basic");
    respond(6, 32'h3F3504F3, "basic");
    finish_ok("basic");

    // backpressure with a competing request held on the input
    res_ready = 1'b0;
    send(32'h3E800000, OP_COS, 2'b10, "bp");
    respond(3, 32'h3F7FF000, "bp");
    req_valid = 1'b1; req_data = 32'h40490FDB; req_operation = OP_SIN; req_region = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      ready_CORDIC = 1'b0;
      chk("bp.hold.rv",  res_valid, 1);
      chk("bp.hold.rd",  res_data, 32'h3F7FF000);
      chk("bp.hold.ack", ACK_FSM_CORDIC, 0);
      chk("bp.hold.rr",  req_ready, 0);
      chk("bp.hold.beg", beg_FSM_CORDIC, 0);
    end
    res_ready = 1'b1;
    tick();
    chk("bp.acc.rv",   res_valid, 0);
    chk("bp.acc.rr",   req_ready, 1);
    chk("bp.acc.beg",  beg_FSM_CORDIC, 0);
    chk("bp.acc.opnd", cordic_data_in, 32'h3E800000);
    tick();
    req_valid = 1'b0;
    chk("bp2.beg",  beg_FSM_CORDIC, 1);
    chk("bp2.opnd", cordic_data_in, 32'h40490FDB);
    chk("bp2.rgn",  shift_region_flag, 2'b11);
    respond(2, 32'h3F800000, "bp2");
    finish_ok("bp2");

    // timeout: abort 8 cycles after entering WAIT
    send(32'h3F000000, OP_SIN, 2'b00, "to");
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("to.wcrst", cordic_reset, 0);
      chk("to.wrv",   res_valid, 0);
    end
    tick();
    chk("to.crst", cordic_reset, 1);
    chk("to.rv",   res_valid, 1);
    chk("to.rto",  res_timeout, 1);
    chk("to.rd",   res_data, 0);
    chk("to.ack",  ACK_FSM_CORDIC, 0);
    tick();
    chk("to.crst0", cordic_reset, 0);
    chk("to.rv0",   res_valid, 0);
    chk("to.rrdy",  req_ready, 1);

    // boundary: completion on the limit cycle wins
    send(32'h3F100000, OP_COS, 2'b01, "bnd");
    respond(9, 32'h3F5DB3D7, "bnd");
    finish_ok("bnd");
    chk("bnd.crst0", cordic_reset, 0);

    // reset in WAIT abandons the transaction
    send(32'h3F200000, OP_SIN, 2'b10, "rmid");
    repeat (3) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rmid.rrdy", req_ready, 1);
    chk("rmid.opnd", cordic_data_in, 0);
    chk("rmid.op",   operation, 0);
    chk("rmid.rgn",  shift_region_flag, 0);
    chk("rmid.rv",   res_valid, 0);
    chk("rmid.rd",   res_data, 0);
    ready_CORDIC = 1'b1; cordic_data_out = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rmid.late.ack", ACK_FSM_CORDIC, 0);
      chk("rmid.late.rv",  res_valid, 0);
    end
    ready_CORDIC = 1'b0;
    send(32'h3F300000, OP_COS, 2'b11, "rmid2");
    respond(3, 32'h3F6C835E, "rmid2");
    finish_ok("rmid2");

    // back-to-back: beg pulses 4 cycles apart
    req_valid = 1'b1; req_data = 32'h3F400000; req_operation = OP_SIN; req_region = 2'b00;
    tick();
    chk("b2b.beg1",  beg_FSM_CORDIC, 1);
    chk("b2b.opnd1", cordic_data_in, 32'h3F400000);
    req_data = 32'h3F500000; req_operation = OP_COS; req_region = 2'b11;
    tick();
    chk("b2b.n1beg", beg_FSM_CORDIC, 0);
    ready_CORDIC = 1'b1; cordic_data_out = 32'h3F2F0000;
    tick();
    chk("b2b.ack", ACK_FSM_CORDIC, 1);
    chk("b2b.rd",  res_data, 32'h3F2F0000);
    chk("b2b.n2beg", beg_FSM_CORDIC, 0);
    tick();
    ready_CORDIC = 1'b0;
    chk("b2b.n3beg", beg_FSM_CORDIC, 0);
    chk("b2b.n3rr",  req_ready, 1);
    chk("b2b.n3opnd", cordic_data_in, 32'h3F400000);
    tick();
    req_valid = 1'b0;
    chk("b2b.beg2",  beg_FSM_CORDIC, 1);
    chk("b2b.opnd2", cordic_data_in, 32'h3F500000);
    chk("b2b.op2",   operation, OP_COS);
    chk("b2b.rgn2",  shift_region_flag, 2'b11);
    respond(2, 32'h3F0F0000, "b2b2");
    finish_ok("b2b2");

    excl_on = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_req_sequencer.md
Name: cordic_req_sequencer

Overview:
Upstream front-end of the CORDIC FSM core. It accepts one sine/cosine request from the host over a valid/ready handshake and latches the operand, operation and region flag. It then pulses the core's start input, waits for the core's done flag, captures the result and returns the core's acknowledge. The result is presented to the host over a valid/ready handshake. A watchdog aborts the operation and resets the core if it never completes.

Parameters:
W, 32, operand/result width (IEEE single).
MAX_WAIT, 1024, maximum cycles in WAIT before abort; must be ≥ 2.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
req_valid  in  1  host request valid
req_ready  out  1  sequencer can accept a request
req_data  in  W  angle operand
req_operation  in  1  0 = cosine, 1 = sine
req_region  in  2  region flag from the range-detect stage
cordic_data_in  out  W  latched operand to core
operation  out  1  latched operation to core
shift_region_flag  out  2  latched region flag to core
beg_FSM_CORDIC  out  1  core start, 1-cycle pulse
ready_CORDIC  in  1  core done, held until acknowledged
cordic_data_out  in  W  core result
ACK_FSM_CORDIC  out  1  core result acknowledge, 1-cycle pulse
cordic_reset  out  1  active-high 1-cycle core reset on abort
res_valid  out  1  result valid to host
res_ready  in  1  host accepts result
res_data  out  W  result
res_timeout  out  1  qualifies res_data: 1 = aborted, res_data = 0

Behaviour:
- All state and outputs are registered except req_ready, which equals (state == IDLE).
- Reset (reset = 0 at a clock edge) forces:
  - state = IDLE, wait counter = 0.
  - All outputs = 0 except req_ready = 1.
  - Reset mid-operation abandons the transaction with no ACK and no result.
- States: IDLE, LAUNCH, WAIT, ACK, ABORT, HOLD.
- IDLE:
  - req_valid = 1 at edge N latches req_data/req_operation/req_region into cordic_data_in/operation/shift_region_flag.
  - Transition to LAUNCH.
  - The latched values stay stable until re-entering IDLE.
- LAUNCH (cycle N+1): beg_FSM_CORDIC = 1 for exactly this cycle; wait counter cleared; go to WAIT.
- WAIT (from N+2): the counter increments each cycle.
  - ready_CORDIC = 1: capture cordic_data_out into res_data, res_timeout = 0, go to ACK.
  - Counter == MAX_WAIT-1 with ready_CORDIC = 0: go to ABORT.
  - ready_CORDIC = 1 on the limit cycle: completion wins, no abort.
- ACK: ACK_FSM_CORDIC = 1 for exactly one cycle; res_valid = 1.
  - res_ready = 1: go to IDLE.
  - Otherwise: go to HOLD.
- ABORT: cordic_reset = 1 for exactly one cycle; res_data = 0; res_timeout = 1; res_valid = 1. Next state follows the same rule as ACK.
- HOLD: res_valid = 1 and res_data/res_timeout stay stable until res_ready = 1, then go to IDLE.
- res_valid deasserts on the cycle after acceptance.
- Latency: req accept at N → beg pulse at N+1. ready_CORDIC seen at M → ACK pulse and res_valid at M+1. Minimum request-to-request throughput is 4 cycles.
- No overlap: req_ready = 0 from LAUNCH through HOLD, even if res_ready is high.
- ready_CORDIC high outside WAIT is ignored.
- beg_FSM_CORDIC, ACK_FSM_CORDIC and cordic_reset are never high in the same cycle.
- The wait counter width is clog2(MAX_WAIT). It never wraps because it is bounded by the abort.

Decomposition:
- Package cordic_seq_pkg:
  - State encoding localparams (IDLE..HOLD, 3 bits).
  - Default MAX_WAIT.
  - Operation constants OP_COS = 0, OP_SIN = 1.
- One sub-module, cordic_wait_watchdog:
  - Parameter MAX_WAIT.
  - Inputs clear, enable.
  - Output expired = (count == MAX_WAIT-1).
  - Synchronous active-low reset.

Test Plan:
- Basic: req_data = 32'h3F490FDB, req_operation = 1, req_region = 2'b01 at edge N; core model asserts ready_CORDIC at N+6 with cordic_data_out = 32'h3F3504F3; res_ready = 1 → beg pulse at N+1, ACK pulse at N+7, res_valid = 1 at N+7 with res_data = 32'h3F3504F3, res_timeout = 0, req_ready = 1 at N+8.
- Backpressure: as basic but res_ready held 0 for 5 cycles → res_valid and res_data stable for all 5 cycles, ACK still exactly 1 cycle, req_valid ignored until the cycle after res_ready = 1.
- Timeout: MAX_WAIT = 8, ready_CORDIC never asserted → ABORT 8 cycles after entering WAIT, cordic_reset 1-cycle pulse, res_valid = 1, res_timeout = 1, res_data = 0, no ACK pulse.
- Boundary: MAX_WAIT = 8, ready_CORDIC first asserted exactly on the counter == 7 cycle → ACK path taken, res_timeout = 0, no cordic_reset.
- Reset mid-operation: reset = 0 during WAIT → next cycle all outputs 0, req_ready = 1. A later ready_CORDIC produces no ACK. A new request then completes normally.
- Back-to-back: two requests with req_valid held high and the core responding in 1 cycle → second beg pulse exactly 4 cycles after the first (res_ready = 1), operands latched per request.
